cam_pattern_stream: RTL and testbench
=====================================

# cam_pattern_stream

Parametrised camera-model pixel source that emits frames of synthetic image data as a valid/ready stream with start-of-frame and end-of-line markers, selectable test patterns, multi-channel pixels and programmable horizontal/vertical blanking. It replaces the free-running fixed-image camera model as the front end of the image pipeline, both in simulation and on the FPGA. It also respects downstream backpressure, so filters and DMA blocks can be exercised under realistic stall conditions.

## Interface
- IMG_WIDTH, 640, active pixels per line (≥2)
- IMG_HEIGHT, 480, active lines per frame (≥2)
- DATA_WIDTH, 8, bits per channel
- CHANNELS, 1, channels per pixel (1..4)
- H_BLANK, 0, idle cycles after every line except the last (0 allowed)
- V_BLANK, 0, idle cycles after the last line of a frame (0 allowed)
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  run request, sampled only at frame boundaries
- mode  in  2  pattern select, sampled only at frame boundaries
- m_valid  out  1  pixel valid
- m_ready  in  1  downstream accepts pixel
- m_data  out  CHANNELS*DATA_WIDTH  pixel; channel 0 in the LSBs
- m_sof  out  1  high with pixel (0,0)
- m_eol  out  1  high with the last pixel of each line
- hcount  out  $clog2(IMG_WIDTH)  column of the presented pixel
- vcount  out  $clog2(IMG_HEIGHT)  row of the presented pixel
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: m_valid=0. If enable=1, latch mode, clear hcount/vcount, go to ACTIVE.
- ACTIVE: m_valid=1. A beat transfers on m_valid&&m_ready. After a transfer:
  - If the pixel is not last-in-line, increment hcount.
  - If the pixel is last-in-line and not the last line: hcount→0, vcount+1. Go to HBLANK if H_BLANK>0, else stay in ACTIVE.
  - If the pixel is the last of the frame: frame_cnt+1, hcount and vcount→0. Go to VBLANK if V_BLANK>0. Otherwise apply the frame-boundary decision: if enable=1, latch mode and stay in ACTIVE; if enable=0, go to IDLE.
- HBLANK/VBLANK: m_valid=0. A down-counter runs for exactly H_BLANK/V_BLANK cycles regardless of m_ready. At expiry, HBLANK returns to ACTIVE. VBLANK applies the frame-boundary decision.
- enable and mode changes inside a frame have no effect. A started frame always completes.
- Patterns, base value b (all sums mod 2^DATA_WIDTH):
  - 0 H-ramp: b=hcount
  - 1 V-ramp: b=vcount
  - 2 checker: b=all-ones if (hcount[3]^vcount[3]), else 0
  - 3 moving: b=hcount+vcount+frame_cnt[DATA_WIDTH-1:0]
- Channel c = b+c (mod 2^DATA_WIDTH).
- m_sof = (hcount==0 && vcount==0 && m_valid). m_eol = (hcount==IMG_WIDTH-1 && m_valid).

## Timing
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, hcount=0, vcount=0, frame_cnt=0, busy=0, state IDLE.
- Reset mid-frame aborts immediately. The first pixel after release is (0,0), with frame_cnt=0.
- All outputs are registered. enable sampled high in IDLE at edge N gives m_valid=1 with pixel (0,0) after edge N.
- Stall rule: while m_valid=1 and m_ready=0, m_data, m_sof, m_eol, hcount and vcount hold stable.
- m_valid is never withdrawn before a transfer.
- With m_ready tied high and enable held high, frame period is IMG_WIDTH*IMG_HEIGHT + (IMG_HEIGHT-1)*H_BLANK + V_BLANK cycles, with no gap between frames beyond that.
- frame_cnt updates on the edge that accepts the last pixel.
- Mode 3 uses the incremented frame_cnt in the next frame.

## Test plan
- W=4,H=3,mode 0,ready=1,blanks 0 -> 12 contiguous beats; data 0,1,2,3 per line; m_sof on beat 0; m_eol on beats 3,7,11; frame_cnt=1 after beat 11.
- Same setup, CHANNELS=3,DATA_WIDTH=8, mode 2 with W=H=16 -> pixel (8,0) = 0x0100FF-style sequence {FF,00,01} packed as 0x0100FF; pixel (8,8) = 0x020100.
- H_BLANK=2,V_BLANK=5,W=4,H=3,ready=1 -> m_valid low exactly 2 cycles after lines 0 and 1 and 5 cycles after line 2; period 21 cycles.
- Random m_ready (~50%) over 3 frames -> every pixel (h,v) appears exactly once in raster order; outputs stable during every stall; frame_cnt=3.
- Mode 3, W=4,H=2 with enable held -> pixel (0,0) data is 0,1,2 in frames 0,1,2. Mode changed mid-frame takes effect only from the next m_sof.
- enable dropped mid-frame -> frame completes, then IDLE with busy=0. Assert rst at pixel (2,1) -> m_valid=0 immediately; restart yields (0,0) with frame_cnt=0.

Source files
------------

// File: rtl/cam_pattern_stream.sv
// Synthetic camera pixel source: raster frames of test patterns on a
// valid/ready stream with SOF/EOL markers, blanking and backpressure.
module cam_pattern_stream #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned H_BLANK    = 0,
    parameter int unsigned V_BLANK    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [1:0]                         mode,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0]     m_data,
    output logic                               m_sof,
    output logic                               m_eol,
    output logic [$clog2(IMG_WIDTH)-1:0]       hcount,
    output logic [$clog2(IMG_HEIGHT)-1:0]      vcount,
    output logic [15:0]                        frame_cnt,
    output logic                               busy
);

    localparam int unsigned HW    = $clog2(IMG_WIDTH);
    localparam int unsigned VW    = $clog2(IMG_HEIGHT);
    localparam int unsigned PW    = CHANNELS * DATA_WIDTH;
    localparam int unsigned BMAX  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned BW    = (BMAX < 2) ? 1 : $clog2(BMAX);
    localparam int unsigned FCW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_e;

    state_e              state_q, state_d;
    logic [HW-1:0]       hcount_q, hcount_d;
    logic [VW-1:0]       vcount_q, vcount_d;
    logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [BW-1:0]       blank_q, blank_d;
    logic                m_valid_q, m_valid_d;
    logic [PW-1:0]       m_data_q, m_data_d;
    logic                m_sof_q, m_sof_d;
    logic                m_eol_q, m_eol_d;
    logic                busy_q, busy_d;
    logic                boundary;
    logic [DATA_WIDTH-1:0] base;

    // Base value of the selected test pattern at one raster position.
    function automatic logic [DATA_WIDTH-1:0] pattern_base(
        input logic [1:0]     md,
        input logic [HW-1:0]  h,
        input logic [VW-1:0]  v,
        input logic [FCW-1:0] fc
    );
        logic [DATA_WIDTH-1:0] b;
        case (md)
            2'd0:    b = DATA_WIDTH'(h);
            2'd1:    b = DATA_WIDTH'(v);
            2'd2:    b = (((32'(h) ^ 32'(v)) & 32'd8) != 32'd0) ? '1 : '0;
            default: b = DATA_WIDTH'(32'(h) + 32'(v) + 32'(fc));
        endcase
        return b;
    endfunction

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hcount_q    <= '0;
            vcount_q    <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            blank_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            blank_q     <= blank_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sof_q     <= m_sof_d;
            m_eol_q     <= m_eol_d;
            busy_q      <= busy_d;
        end
    end

    // Raster sequencing, blanking and frame-boundary run/mode decision;
    // outputs are derived from the next position so they register with it.
    always_comb begin
        state_d     = state_q;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        blank_d     = blank_q;
        boundary    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    mode_d   = mode;
                    hcount_d = '0;
                    vcount_d = '0;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (m_valid_q && m_ready) begin
                    if (hcount_q != HW'(IMG_WIDTH - 1)) begin
                        hcount_d = hcount_q + HW'(1);
                    end else if (vcount_q != VW'(IMG_HEIGHT - 1)) begin
                        hcount_d = '0;
                        vcount_d = vcount_q + VW'(1);
                        if (H_BLANK != 0) begin
                            state_d = ST_HBLANK;
                            blank_d = BW'(H_BLANK - 1);
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                        hcount_d    = '0;
                        vcount_d    = '0;
                        if (V_BLANK != 0) begin
                            state_d = ST_VBLANK;
                            blank_d = BW'(V_BLANK - 1);
                        end else begin
                            boundary = 1'b1;
                        end
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    blank_d = blank_q - BW'(1);
                end
            end
            ST_VBLANK: begin
                if (blank_q == '0) begin
                    boundary = 1'b1;
                end else begin
                    blank_d = blank_q - BW'(1);
                end
            end
        endcase

        // A completed frame either chains into the next one or parks in IDLE.
        if (boundary) begin
            if (enable) begin
                mode_d  = mode;
                state_d = ST_ACTIVE;
            end else begin
                state_d = ST_IDLE;
            end
        end

        m_valid_d = (state_d == ST_ACTIVE);
        busy_d    = (state_d != ST_IDLE);
        base      = pattern_base(mode_d, hcount_d, vcount_d, frame_cnt_d);
        m_data_d  = '0;
        m_sof_d   = 1'b0;
        m_eol_d   = 1'b0;
        if (m_valid_d) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                m_data_d[c*DATA_WIDTH +: DATA_WIDTH] = base + DATA_WIDTH'(c);
            end
            m_sof_d = (hcount_d == '0) && (vcount_d == '0);
            m_eol_d = (hcount_d == HW'(IMG_WIDTH - 1));
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sof     = m_sof_q;
    assign m_eol     = m_eol_q;
    assign hcount    = hcount_q;
    assign vcount    = vcount_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cam_pattern_stream.sv
// Scoreboard bench for cam_pattern_stream: a 16x16 3-channel instance with
// blanking under backpressure, and a 4x3 single-channel zero-blank instance.
module tb_cam_pattern_stream;

    logic clk;
    logic rst;

    // Instance A: 16x16, 3 channels, H_BLANK=2, V_BLANK=5
    logic        en_a, ready_a, rand_a;
    logic [1:0]  mode_a;
    logic        m_valid_a, m_sof_a, m_eol_a, busy_a;
    logic [23:0] m_data_a;
    logic [3:0]  hcount_a, vcount_a;
    logic [15:0] frame_cnt_a;

    // Instance B: 4x3, 1 channel, no blanking
    logic        en_b, ready_b;
    logic [1:0]  mode_b;
    logic        m_valid_b, m_sof_b, m_eol_b, busy_b;
    logic [7:0]  m_data_b;
    logic [1:0]  hcount_b, vcount_b;
    logic [15:0] frame_cnt_b;

    int n_checks = 0;
    int n_err    = 0;
    int fc_model = 0;

    typedef struct {
        logic [23:0] data;
        int          h;
        int          v;
        logic        sof;
        logic        eol;
        int          fc;
    } px_t;

    typedef struct {
        logic [7:0] data;
        int         h;
        int         v;
        logic       sof;
        logic       eol;
        int         fc;
    } pb_t;

    px_t q_a[$];
    pb_t q_b[$];

    int  beats_b = 0;
    time first_b = 0;
    time last_b  = 0;

    cam_pattern_stream #(
        .IMG_WIDTH(16), .IMG_HEIGHT(16), .DATA_WIDTH(8), .CHANNELS(3),
        .H_BLANK(2), .V_BLANK(5)
    ) u_dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .mode(mode_a),
        .m_valid(m_valid_a), .m_ready(ready_a), .m_data(m_data_a),
        .m_sof(m_sof_a), .m_eol(m_eol_a), .hcount(hcount_a), .vcount(vcount_a),
        .frame_cnt(frame_cnt_a), .busy(busy_a)
    );

    cam_pattern_stream #(
        .IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_WIDTH(8), .CHANNELS(1),
        .H_BLANK(0), .V_BLANK(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .mode(mode_b),
        .m_valid(m_valid_b), .m_ready(ready_b), .m_data(m_data_b),
        .m_sof(m_sof_b), .m_eol(m_eol_b), .hcount(hcount_b), .vcount(vcount_b),
        .frame_cnt(frame_cnt_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endfunction

    // Expected raster of one frame of instance A.
    function automatic void push_frame_a(input int md);
        for (int v = 0; v < 16; v++) begin
            for (int h = 0; h < 16; h++) begin
                px_t e;
                int  b;
                case (md)
                    0:       b = h;
                    1:       b = v;
                    2:       b = (((h / 8) % 2) != ((v / 8) % 2)) ? 255 : 0;
                    default: b = (h + v + fc_model) % 256;
                endcase
                e.data = {8'((b + 2) % 256), 8'((b + 1) % 256), 8'(b)};
                e.h    = h;
                e.v    = v;
                e.sof  = (h == 0 && v == 0);
                e.eol  = (h == 15);
                e.fc   = fc_model;
                q_a.push_back(e);
            end
        end
        fc_model++;
    endfunction

    // Random backpressure driver for instance A.
    initial begin
        ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_a = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor A: beat scoreboard, stall stability, blanking gap lengths.
    initial begin
        logic        stall_prev;
        logic        new_beat;
        int          prev_kind;
        int          gap;
        int          exp_gap;
        logic [23:0] s_data;
        logic [3:0]  s_h, s_v;
        logic        s_sof, s_eol;
        px_t         e;
        stall_prev = 1'b0;
        new_beat   = 1'b1;
        prev_kind  = 0;
        gap        = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                new_beat   = 1'b1;
                prev_kind  = 0;
                gap        = 0;
            end else begin
                if (stall_prev) begin
                    chk("a_stall_valid", m_valid_a, 1'b1);
                    chk("a_stall_data", m_data_a, s_data);
                    chk("a_stall_h", hcount_a, s_h);
                    chk("a_stall_v", vcount_a, s_v);
                    chk("a_stall_sof", m_sof_a, s_sof);
                    chk("a_stall_eol", m_eol_a, s_eol);
                end
                if (m_valid_a) begin
                    if (new_beat) begin
                        if (prev_kind != 0) begin
                            exp_gap = (prev_kind == 1) ? 0 : (prev_kind == 2) ? 2 : 5;
                            chk("a_gap", gap, exp_gap);
                        end
                        gap      = 0;
                        new_beat = 1'b0;
                    end
                    if (ready_a) begin
                        if (q_a.size() == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL a_unexpected_beat: got pixel (%0d,%0d) with no expected entry",
                                     hcount_a, vcount_a);
                        end else begin
                            e = q_a.pop_front();
                            chk("a_data", m_data_a, e.data);
                            chk("a_hcount", hcount_a, e.h);
                            chk("a_vcount", vcount_a, e.v);
                            chk("a_sof", m_sof_a, e.sof);
                            chk("a_eol", m_eol_a, e.eol);
                            chk("a_frame_cnt", frame_cnt_a, e.fc);
                            prev_kind = (e.h != 15) ? 1 : (e.v != 15) ? 2 : 3;
                        end
                        new_beat = 1'b1;
                    end
                end else begin
                    gap++;
                end
                if (!busy_a) prev_kind = 0;
                stall_prev = m_valid_a && !ready_a;
                s_data = m_data_a;
                s_h    = hcount_a;
                s_v    = vcount_a;
                s_sof  = m_sof_a;
                s_eol  = m_eol_a;
            end
        end
    end

    // Monitor B: every valid cycle is a beat (ready tied high).
    initial begin
        pb_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_valid_b) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL b_unexpected_beat: got data 0x%0h with no expected entry", m_data_b);
                end else begin
                    e = q_b.pop_front();
                    chk("b_data", m_data_b, e.data);
                    chk("b_hcount", hcount_b, e.h);
                    chk("b_vcount", vcount_b, e.v);
                    chk("b_sof", m_sof_b, e.sof);
                    chk("b_eol", m_eol_b, e.eol);
                    chk("b_frame_cnt", frame_cnt_b, e.fc);
                end
                if (beats_b == 0) first_b = $time;
                last_b = $time;
                beats_b++;
            end
        end
    end

    task automatic wait_pix_a(input int h, input int v, input int fc, input string tag);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < 4000) begin
            @(negedge clk);
            n++;
            hit = m_valid_a && int'(hcount_a) == h && int'(vcount_a) == v && int'(frame_cnt_a) == fc;
        end
        if (!hit) timeout(tag);
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (busy_a && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (busy_a) timeout(tag);
    endtask

    task automatic run_a();
        time t0, t1;
        // Frame 0 mode 0; mode switched to 2 inside frame 0 applies to frame 1.
        push_frame_a(0);
        push_frame_a(2);
        mode_a = 2'd0;
        en_a   = 1'b1;
        wait_pix_a(0, 0, 0, "a_frame0_start");
        t0 = $time;
        mode_a = 2'd2;
        wait_pix_a(0, 0, 1, "a_frame1_start");
        t1 = $time;
        chk("a_frame_period", (t1 - t0) / 10, 291);
        // Frames 2..4 in moving mode under random backpressure.
        mode_a = 2'd3;
        push_frame_a(3);
        push_frame_a(3);
        push_frame_a(3);
        rand_a = 1'b1;
        wait_pix_a(8, 0, 1, "a_checker_8_0");
        chk("a_checker_8_0", m_data_a, 24'h0100FF);
        wait_pix_a(8, 8, 1, "a_checker_8_8");
        chk("a_checker_8_8", m_data_a, 24'h020100);
        wait_pix_a(0, 0, 4, "a_frame4_start");
        en_a = 1'b0;
        wait_idle_a("a_stop_idle");
        rand_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("a_frame_cnt_after_stop", frame_cnt_a, 16'd5);
        chk("a_idle_valid", m_valid_a, 1'b0);
        chk("a_idle_busy", busy_a, 1'b0);
        // Mid-frame reset at pixel (2,1), then a clean restart.
        mode_a = 2'd1;
        en_a   = 1'b1;
        push_frame_a(1);
        wait_pix_a(2, 1, 5, "a_reset_point");
        #2;
        rst = 1'b1;
        #1;
        chk("a_rst_valid", m_valid_a, 1'b0);
        chk("a_rst_hcount", hcount_a, 4'd0);
        chk("a_rst_vcount", vcount_a, 4'd0);
        chk("a_rst_frame_cnt", frame_cnt_a, 16'd0);
        chk("a_rst_busy", busy_a, 1'b0);
        q_a.delete();
        fc_model = 0;
        push_frame_a(1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_pix_a(0, 0, 0, "a_restart");
        chk("a_restart_sof", m_sof_a, 1'b1);
        en_a = 1'b0;
        wait_idle_a("a_restart_idle");
        repeat (2) @(negedge clk);
        chk("a_restart_drained", q_a.size(), 0);
        chk("a_restart_frame_cnt", frame_cnt_a, 16'd1);
    endtask

    task automatic run_b();
        int tbl_b [36] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3,
                           1, 2, 3, 4, 2, 3, 4, 5, 3, 4, 5, 6,
                           2, 3, 4, 5, 3, 4, 5, 6, 4, 5, 6, 7};
        int n;
        for (int i = 0; i < 36; i++) begin
            pb_t e;
            e.data = 8'(tbl_b[i]);
            e.h    = i % 4;
            e.v    = (i % 12) / 4;
            e.sof  = (i % 12 == 0);
            e.eol  = (i % 4 == 3);
            e.fc   = i / 12;
            q_b.push_back(e);
        end
        mode_b = 2'd0;
        en_b   = 1'b1;
        n = 0;
        while (!m_valid_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid_b) timeout("b_first_beat");
        mode_b = 2'd3;
        n = 0;
        while (!(m_valid_b && frame_cnt_b == 16'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("b_frame2_start");
        en_b = 1'b0;
        n = 0;
        while (busy_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_b) timeout("b_idle");
        repeat (3) @(negedge clk);
        chk("b_beats", beats_b, 36);
        chk("b_contiguous_span", (last_b - first_b) / 10, 35);
        chk("b_queue_drained", q_b.size(), 0);
        chk("b_frame_cnt", frame_cnt_b, 16'd3);
    endtask

    initial begin
        rst    = 1'b1;
        en_a   = 1'b0;
        mode_a = 2'd0;
        rand_a = 1'b0;
        en_b   = 1'b0;
        mode_b = 2'd0;
        ready_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a_valid", m_valid_a, 1'b0);
        chk("rst_a_data", m_data_a, 24'd0);
        chk("rst_a_sof", m_sof_a, 1'b0);
        chk("rst_a_eol", m_eol_a, 1'b0);
        chk("rst_a_hcount", hcount_a, 4'd0);
        chk("rst_a_vcount", vcount_a, 4'd0);
        chk("rst_a_frame_cnt", frame_cnt_a, 16'd0);
        chk("rst_a_busy", busy_a, 1'b0);
        chk("rst_b_valid", m_valid_b, 1'b0);
        chk("rst_b_busy", busy_b, 1'b0);
        rst = 1'b0;
        fork
            run_a();
            run_b();
        join
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
